// File: rtl/telem_write_scheduler.sv
// Telemetry write scheduler. Three sensors compete round-robin for a single
// write port into a 16-entry target register file. A live mask tracks which
// targets hold data, and a purge sweep walks all 16 entries, dropping those
// whose time stamp is older than a snapshot of the age limit.
module telem_write_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  s_valid,
  output logic [2:0]  s_ready,
  input  logic [11:0] s_target,
  input  logic [23:0] s_x,
  input  logic [23:0] s_y,
  input  logic [23:0] s_z,
  input  logic        tick,
  input  logic        purge_req,
  input  logic [7:0]  age_limit,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic [7:0]  wr_x,
  output logic [7:0]  wr_y,
  output logic [7:0]  wr_z,
  output logic [7:0]  wr_t,
  output logic [3:0]  rd_sel,
  input  logic [7:0]  rd_t,
  output logic [15:0] live_mask,
  output logic [4:0]  live_count,
  output logic        busy,
  output logic        purge_done,
  output logic [7:0]  now
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e      r_state;
  logic [1:0]  r_ptr;
  logic [7:0]  r_now;
  logic [15:0] r_live;
  logic [3:0]  r_idx;
  logic [7:0]  r_snap_now;
  logic [7:0]  r_snap_lim;
  logic        r_busy;
  logic        r_purge_done;

  logic        r_wr_en;
  logic [3:0]  r_wr_sel;
  logic [7:0]  r_wr_x;
  logic [7:0]  r_wr_y;
  logic [7:0]  r_wr_z;
  logic [7:0]  r_wr_t;

  logic        w_grant_ok;
  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic        w_any;
  logic [1:0]  w_win;
  logic [1:0]  w_ptr_nxt;
  logic [3:0]  w_tgt;
  logic [7:0]  w_x;
  logic [7:0]  w_y;
  logic [7:0]  w_z;
  logic [7:0]  w_age;
  logic        w_stale;
  logic [15:0] w_live_d;
  logic [4:0]  w_count;

  // Grants only in IDLE; a purge request or reset in the same cycle blocks them.
  assign w_grant_ok = (r_state == StIdle) && !purge_req && !rst;

  // Search order starting at the priority pointer.
  always_comb begin
    w_c0 = 2'd0;
    w_c1 = 2'd1;
    w_c2 = 2'd2;
    case (r_ptr)
      2'd1: begin
        w_c0 = 2'd1;
        w_c1 = 2'd2;
        w_c2 = 2'd0;
      end
      2'd2: begin
        w_c0 = 2'd2;
        w_c1 = 2'd0;
        w_c2 = 2'd1;
      end
      default: begin
        w_c0 = 2'd0;
        w_c1 = 2'd1;
        w_c2 = 2'd2;
      end
    endcase
  end

  // Pick the first requesting sensor in rotated order.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    if (w_grant_ok) begin
      if (s_valid[w_c0]) begin
        w_any = 1'b1;
        w_win = w_c0;
      end else if (s_valid[w_c1]) begin
        w_any = 1'b1;
        w_win = w_c1;
      end else if (s_valid[w_c2]) begin
        w_any = 1'b1;
        w_win = w_c2;
      end
    end
  end

  assign s_ready   = w_any ? (3'b001 << w_win) : 3'b000;
  assign w_ptr_nxt = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;

  // Select the winning sensor's target and coordinate fields.
  always_comb begin
    w_tgt = s_target[3:0];
    w_x   = s_x[7:0];
    w_y   = s_y[7:0];
    w_z   = s_z[7:0];
    case (w_win)
      2'd1: begin
        w_tgt = s_target[7:4];
        w_x   = s_x[15:8];
        w_y   = s_y[15:8];
        w_z   = s_z[15:8];
      end
      2'd2: begin
        w_tgt = s_target[11:8];
        w_x   = s_x[23:16];
        w_y   = s_y[23:16];
        w_z   = s_z[23:16];
      end
      default: begin
        w_tgt = s_target[3:0];
        w_x   = s_x[7:0];
        w_y   = s_y[7:0];
        w_z   = s_z[7:0];
      end
    endcase
  end

  // Priority pointer moves past the sensor that just transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Free-running time base advanced by tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_now <= 8'd0;
    end else if (tick) begin
      r_now <= r_now + 8'd1;
    end
  end

  // Write port: one-cycle strobe after a transfer, fields hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en  <= 1'b0;
      r_wr_sel <= 4'd0;
      r_wr_x   <= 8'd0;
      r_wr_y   <= 8'd0;
      r_wr_z   <= 8'd0;
      r_wr_t   <= 8'd0;
    end else begin
      r_wr_en <= w_any;
      if (w_any) begin
        r_wr_sel <= w_tgt;
        r_wr_x   <= w_x;
        r_wr_y   <= w_y;
        r_wr_z   <= w_z;
        r_wr_t   <= r_now;
      end
    end
  end

  // Age is measured modulo 256 against the snapshot taken at purge start.
  assign w_age   = r_snap_now - rd_t;
  assign w_stale = (r_state == StScan) && r_live[r_idx] && (w_age > r_snap_lim);

  // Clear stale entry first, then apply the write so a same-cycle set wins.
  always_comb begin
    w_live_d = r_live;
    if (w_stale) begin
      w_live_d[r_idx] = 1'b0;
    end
    if (r_wr_en) begin
      w_live_d[r_wr_sel] = 1'b1;
    end
  end

  // Live mask register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live <= 16'd0;
    end else begin
      r_live <= w_live_d;
    end
  end

  // Population count of the live mask.
  always_comb begin
    w_count = 5'd0;
    for (int k = 0; k < 16; k++) begin
      w_count = w_count + {4'd0, r_live[k]};
    end
  end

  // Purge sweep FSM with registered busy and done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_idx        <= 4'd0;
      r_snap_now   <= 8'd0;
      r_snap_lim   <= 8'd0;
      r_busy       <= 1'b0;
      r_purge_done <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_purge_done <= 1'b0;
          if (purge_req) begin
            r_snap_now <= r_now;
            r_snap_lim <= age_limit;
            r_idx      <= 4'd0;
            r_busy     <= 1'b1;
            r_state    <= StScan;
          end
        end
        StScan: begin
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_purge_done <= 1'b1;
            r_state      <= StDone;
          end
        end
        StDone: begin
          r_purge_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= StIdle;
        end
        default: begin
          r_purge_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= StIdle;
        end
      endcase
    end
  end

  // Reset suppresses a strobe already queued from the previous cycle.
  assign wr_en      = r_wr_en & ~rst;
  assign wr_sel     = r_wr_sel;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign wr_z       = r_wr_z;
  assign wr_t       = r_wr_t;
  assign rd_sel     = (r_state == StScan) ? r_idx : 4'd0;
  assign live_mask  = r_live;
  assign live_count = w_count;
  assign busy       = r_busy;
  assign purge_done = r_purge_done;
  assign now        = r_now;

endmodule

// File: tb/tb_telem_write_scheduler.sv
// Self-checking bench for telem_write_scheduler: directed scenarios followed by
// random traffic, all compared every cycle against a transaction-level model.
module tb_telem_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic [11:0] s_target;
  logic [23:0] s_x;
  logic [23:0] s_y;
  logic [23:0] s_z;
  logic        tick;
  logic        purge_req;
  logic [7:0]  age_limit;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [7:0]  wr_z;
  logic [7:0]  wr_t;
  logic [3:0]  rd_sel;
  logic [7:0]  rd_t;
  logic [15:0] live_mask;
  logic [4:0]  live_count;
  logic        busy;
  logic        purge_done;
  logic [7:0]  now;

  always #5 clk = ~clk;

  telem_write_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_target   (s_target),
    .s_x        (s_x),
    .s_y        (s_y),
    .s_z        (s_z),
    .tick       (tick),
    .purge_req  (purge_req),
    .age_limit  (age_limit),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_z       (wr_z),
    .wr_t       (wr_t),
    .rd_sel     (rd_sel),
    .rd_t       (rd_t),
    .live_mask  (live_mask),
    .live_count (live_count),
    .busy       (busy),
    .purge_done (purge_done),
    .now        (now)
  );

  // Time-coordinate column of the external target file.
  logic [7:0] tfile [16];
  always @(posedge clk) if (wr_en) tfile[wr_sel] <= wr_t;
  assign rd_t = tfile[rd_sel];

  int vecs = 0;
  int errs = 0;

  // Reference model: mode 0 idle, 1 sweeping, 2 done.
  int          m_now, m_ptr, m_mode, m_k, m_snap, m_lim;
  logic [15:0] m_live;
  int          m_stamp [16];
  bit          m_pend;
  logic [3:0]  m_sel;
  logic [7:0]  m_x, m_y, m_z, m_t;

  logic [2:0]  obs_ready;
  logic        obs_wr_en;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_now = 0; m_ptr = 0; m_mode = 0; m_k = 0; m_snap = 0; m_lim = 0;
    m_live = '0; m_pend = 0;
    m_sel = '0; m_x = '0; m_y = '0; m_z = '0; m_t = '0;
  endfunction

  // One clock: check every output against the model, advance the model.
  task automatic cycle();
    int win;
    int pc;
    logic [2:0] e_ready;
    #1;
    win = -1;
    if (m_mode == 0 && !purge_req && !rst) begin
      for (int j = 0; j < 3; j++) begin
        if (win < 0 && s_valid[(m_ptr + j) % 3]) win = (m_ptr + j) % 3;
      end
    end
    e_ready = (win < 0) ? 3'b000 : 3'(1 << win);
    pc = 0;
    for (int e = 0; e < 16; e++) pc += int'(m_live[e]);
    chk("s_ready", 32'(s_ready), 32'(e_ready));
    chk("wr_en", 32'(wr_en), 32'(m_pend && !rst));
    chk("wr_sel", 32'(wr_sel), 32'(m_sel));
    chk("wr_x", 32'(wr_x), 32'(m_x));
    chk("wr_y", 32'(wr_y), 32'(m_y));
    chk("wr_z", 32'(wr_z), 32'(m_z));
    chk("wr_t", 32'(wr_t), 32'(m_t));
    chk("live_mask", 32'(live_mask), 32'(m_live));
    chk("live_count", 32'(live_count), 32'(pc));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("purge_done", 32'(purge_done), 32'(m_mode == 2));
    chk("rd_sel", 32'(rd_sel), 32'((m_mode == 1) ? m_k : 0));
    chk("now", 32'(now), 32'(m_now));
    obs_ready = s_ready;
    obs_wr_en = wr_en;
    obs_busy  = busy;
    if (rst) begin
      model_reset();
    end else begin
      if (m_mode == 1 && m_live[m_k] && ((m_snap - m_stamp[m_k] + 256) % 256) > m_lim)
        m_live[m_k] = 1'b0;
      if (m_pend) begin
        m_live[m_sel]   = 1'b1;
        m_stamp[m_sel]  = int'(m_t);
      end
      m_pend = 0;
      if (win >= 0) begin
        m_pend = 1;
        m_sel  = s_target[4*win +: 4];
        m_x    = s_x[8*win +: 8];
        m_y    = s_y[8*win +: 8];
        m_z    = s_z[8*win +: 8];
        m_t    = 8'(m_now);
        m_ptr  = (win + 1) % 3;
      end
      case (m_mode)
        0: if (purge_req) begin
          m_mode = 1; m_k = 0; m_snap = m_now; m_lim = int'(age_limit);
        end
        1: if (m_k == 15) m_mode = 2; else m_k++;
        default: m_mode = 0;
      endcase
      if (tick) m_now = (m_now + 1) % 256;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    s_valid = '0; tick = 1'b0; purge_req = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic put(input int i, input logic [3:0] t, input logic [7:0] x);
    s_target[4*i +: 4] = t;
    s_x[8*i +: 8] = x;
    s_y[8*i +: 8] = x ^ 8'hA5;
    s_z[8*i +: 8] = x + 8'd3;
  endtask

  task automatic run_purge(input logic [7:0] lim);
    quiet();
    purge_req = 1'b1;
    age_limit = lim;
    cycle();
    purge_req = 1'b0;
    for (int n = 0; n < 17; n++) cycle();
    chk("purge_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0] g_exp [4];
    int bc, pd_at, pd_n;
    bit found;

    rst = 1'b1; quiet(); age_limit = '0; s_target = '0; s_x = '0; s_y = '0; s_z = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset dominates tick, purge and requests in the same cycle.
    s_valid = 3'b111; tick = 1'b1; purge_req = 1'b1;
    cycle();
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_live", 32'(live_mask), 32'd0);
    chk("rst_count", 32'(live_count), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_sel", 32'(rd_sel), 32'd0);
    rst = 1'b0;
    quiet();

    // Single transfer from sensor 0.
    put(0, 4'd11, 8'h55);
    s_valid = 3'b001;
    cycle();
    chk("r031_ready", 32'(obs_ready), 32'b001);
    quiet();
    chk("r031_wr_en", 32'(wr_en), 32'd1);
    chk("r031_wr_sel", 32'(wr_sel), 32'd11);
    chk("r031_wr_x", 32'(wr_x), 32'h55);
    chk("r031_wr_t", 32'(wr_t), 32'd0);
    cycle();
    chk("r031_mask", 32'(live_mask), 32'h0800);
    chk("r031_count", 32'(live_count), 32'd1);

    // Round-robin with all sensors requesting.
    do_reset();
    put(0, 4'd1, 8'h10); put(1, 4'd2, 8'h20); put(2, 4'd3, 8'h30);
    g_exp[0] = 3'b001; g_exp[1] = 3'b010; g_exp[2] = 3'b100; g_exp[3] = 3'b001;
    s_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("r032_grant", 32'(obs_ready), 32'(g_exp[n]));
      chk("r032_wr_en", 32'(wr_en), 32'd1);
    end
    quiet();
    cycle();
    chk("r032_wr_en_end", 32'(wr_en), 32'd0);

    // Aged entry is purged, fresh one survives.
    do_reset();
    put(1, 4'd2, 8'h77);
    s_valid = 3'b010;
    cycle();
    quiet();
    tick = 1'b1;
    repeat (10) cycle();
    tick = 1'b0;
    put(0, 4'd5, 8'h99);
    s_valid = 3'b001;
    cycle();
    quiet();
    purge_req = 1'b1; age_limit = 8'd5;
    cycle();
    purge_req = 1'b0;
    bc = 0; pd_at = 0; pd_n = 0;
    for (int n = 0; n < 25; n++) begin
      if (busy) bc++;
      if (purge_done) begin pd_at = bc; pd_n++; end
      cycle();
    end
    chk("r033_busy_cycles", 32'(bc), 32'd17);
    chk("r033_done_at", 32'(pd_at), 32'd17);
    chk("r033_done_pulses", 32'(pd_n), 32'd1);
    chk("r033_mask", 32'(live_mask), 32'h0020);

    // Purge right behind a write; requests during the sweep are refused.
    do_reset();
    put(2, 4'd0, 8'h42);
    s_valid = 3'b100;
    cycle();
    quiet();
    chk("r034_wr_en", 32'(wr_en), 32'd1);
    purge_req = 1'b1; age_limit = 8'd0;
    cycle();
    purge_req = 1'b0;
    s_valid = 3'b111;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      cycle();
      if (obs_busy) chk("r034_ready_busy", 32'(obs_ready), 32'd0);
      else found = 1;
    end
    chk("r034_sweep_ends", 32'(found), 32'd1);
    chk("r034_mask0", 32'(live_mask[0]), 32'd1);
    quiet();
    cycle();

    // Time base wrap and boundary age.
    do_reset();
    tick = 1'b1;
    repeat (254) cycle();
    chk("r035_now254", 32'(now), 32'd254);
    put(0, 4'd7, 8'h3C);
    s_valid = 3'b001;
    cycle();
    s_valid = '0;
    chk("r035_now255", 32'(now), 32'd255);
    repeat (2) cycle();
    chk("r035_wrap", 32'(now), 32'd1);
    run_purge(8'd3);
    chk("r035_survive", 32'(live_mask[7]), 32'd1);
    run_purge(8'd2);
    chk("r035_cleared", 32'(live_mask[7]), 32'd0);

    // Reset in the middle of a sweep.
    do_reset();
    put(0, 4'd3, 8'h11); put(1, 4'd9, 8'h22);
    s_valid = 3'b011;
    repeat (2) cycle();
    quiet();
    cycle();
    purge_req = 1'b1; age_limit = 8'd100;
    cycle();
    purge_req = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (rd_sel == 4'd7 && busy) found = 1;
      else cycle();
    end
    chk("r036_reach7", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("r036_busy", 32'(busy), 32'd0);
    chk("r036_mask", 32'(live_mask), 32'd0);
    pd_n = 0;
    for (int n = 0; n < 20; n++) begin
      if (purge_done) pd_n++;
      cycle();
    end
    chk("r036_no_done", 32'(pd_n), 32'd0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      s_valid   = 3'($urandom);
      s_target  = 12'($urandom);
      s_x       = 24'($urandom);
      s_y       = 24'($urandom);
      s_z       = 24'($urandom);
      tick      = 1'($urandom);
      purge_req = ($urandom_range(0, 24) == 0);
      age_limit = 8'($urandom_range(0, 40));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
